// File: rtl/drum_mult_pipe.sv
// drum_mult_pipe: 3-stage pipelined DRUM unsigned multiplier with valid/ready flow control.
// Define DRUM_EXACT_EN to add the exact_i port and a per-pair full-width exact mode.
module drum_mult_pipe #(
    parameter int WIDTH = 16,
    parameter int K     = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
`ifdef DRUM_EXACT_EN
    input  logic                 exact_i,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   r
);
    localparam int LW = $clog2(WIDTH);
`ifdef DRUM_EXACT_EN
    localparam int MW = WIDTH;
`else
    localparam int MW = K;
`endif

    if (WIDTH < 4 || WIDTH > 32 || K < 3 || K > WIDTH) begin : g_bad_param
        $error("drum_mult_pipe: illegal WIDTH/K");
    end

    function automatic logic [LW-1:0] lead(input logic [WIDTH-1:0] x);
        lead = '0;
        for (int i = 0; i < WIDTH; i++)
            if (x[i]) lead = LW'(i);
    endfunction

    logic [LW-1:0] la, lb, pa, pb, pa_n, pb_n, pa1, pb1;
    logic [K-1:0]  wa, wb;
    logic [MW-1:0] wa_n, wb_n, wa1, wb1;
    logic [2*MW-1:0] t2;
    logic [LW:0]   s2;
    logic          v1, v2, v3, en1, en2, en3;

    // Window starts at the leading one; its LSB is forced to 1 to unbias truncation.
    always_comb begin
        la = lead(a);
        lb = lead(b);
        pa = int'(la) >= K ? LW'(int'(la) - K + 1) : '0;
        pb = int'(lb) >= K ? LW'(int'(lb) - K + 1) : '0;
        wa = int'(la) >= K ? K'(a >> pa) | K'(1) : a[K-1:0];
        wb = int'(lb) >= K ? K'(b >> pb) | K'(1) : b[K-1:0];
`ifdef DRUM_EXACT_EN
        wa_n = exact_i ? a : MW'(wa);
        wb_n = exact_i ? b : MW'(wb);
        pa_n = exact_i ? '0 : pa;
        pb_n = exact_i ? '0 : pb;
`else
        wa_n = wa;
        wb_n = wb;
        pa_n = pa;
        pb_n = pb;
`endif
    end

    assign en3       = !v3 | out_ready;
    assign en2       = !v2 | en3;
    assign en1       = !v1 | en2;
    assign in_ready  = en1;
    assign out_valid = v3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {v1, v2, v3} <= '0;
            {wa1, wb1, pa1, pb1} <= '0;
            {t2, s2} <= '0;
            r <= '0;
        end else begin
            if (en1) begin
                v1 <= in_valid;
                if (in_valid) {wa1, wb1, pa1, pb1} <= {wa_n, wb_n, pa_n, pb_n};
            end
            if (en2) begin
                v2 <= v1;
                if (v1) begin
                    t2 <= (2*MW)'(wa1) * (2*MW)'(wb1);
                    s2 <= (LW+1)'(pa1) + (LW+1)'(pb1);
                end
            end
            if (en3) begin
                v3 <= v2;
                if (v2) r <= (2*WIDTH)'(t2) << s2;
            end
        end
    end
endmodule

// File: tb/tb_drum_mult_pipe.sv
// tb_drum_mult_pipe: table vectors, random stream, backpressure and reset corners for drum_mult_pipe.
module tb_drum_mult_pipe;
    localparam int W = 16;

    logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 1;
    logic [W-1:0] a = '0, b = '0;
`ifdef DRUM_EXACT_EN
    logic exact_i = 0;
`endif
    logic in_ready, out_valid;
    logic [2*W-1:0] r;

    drum_mult_pipe #(.WIDTH(W), .K(5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b),
`ifdef DRUM_EXACT_EN
        .exact_i(exact_i),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .r(r));

    always #5 clk = ~clk;

    int errors = 0, checks = 0, ov_cnt = 0, run = 0, max_run = 0;
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] cur_exp = '0;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] r;
    } vec_t;
    vec_t tv[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void win(input logic [W-1:0] x, output longint w, output int p);
        int k = 0;
        for (int i = 0; i < W; i++) if (x[i]) k = i;
        if (k >= 5) begin
            p = k - 4;
            w = (longint'(x) >> p) | 64'd1;
        end else begin
            p = 0;
            w = longint'(x);
        end
    endfunction

    function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
        longint wx, wy;
        int px, py;
        win(x, wx, px);
        win(y, wy, py);
        return (2*W)'((wx * wy) << (px + py));
    endfunction

    // Scoreboard: push on accepted input, pop and compare on emitted output.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            run = 0;
        end else begin
            if (in_valid && in_ready) exp_q.push_back(cur_exp);
            if (out_valid) begin
                ov_cnt++;
                run++;
                if (run > max_run) max_run = run;
            end else run = 0;
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out: got r=%0h with no pending pair", r);
                end else begin
                    logic [2*W-1:0] e;
                    e = exp_q.pop_front();
                    if (r !== e) begin
                        errors++;
                        $display("FAIL scoreboard_r: got %0h expected %0h", r, e);
                    end
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2*W-1:0] e);
        a = x; b = y; cur_exp = e; in_valid = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        check("send_accept", in_ready, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        check("drain_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Pair registered at the edge ending the send: visible after two more edges.
    task automatic lat_check(input logic [2*W-1:0] e);
        in_valid = 0;
        repeat (2) begin
            @(negedge clk);
            check("lat_idle", out_valid, 0);
        end
        @(negedge clk);
        check("lat_valid", out_valid, 1);
        check("lat_r", r, e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] x, y;
        tv[0] = '{16'hFFFF, 16'hFFFF, 32'hF0400000};
        tv[1] = '{16'd1000, 16'd1000, 32'd984064};
        tv[2] = '{16'd0,    16'hFFFF, 32'd0};
        tv[3] = '{16'hFFFF, 16'd0,    32'd0};
        tv[4] = '{16'd31,   16'd31,   32'd961};
        tv[5] = '{16'h8000, 16'h8000, 32'h48400000};

        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_r", r, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        send(16'd3, 16'd7, 32'd21);
        lat_check(32'd21);

        foreach (tv[i]) send(tv[i].a, tv[i].b, tv[i].r);
        drain();

        ov_cnt = 0;
        max_run = 0;
        for (int i = 0; i < 10; i++) begin
            x = W'($urandom) >> $urandom_range(0, 15);
            y = W'($urandom) >> $urandom_range(0, 15);
            send(x, y, model(x, y));
        end
        drain();
        check("stream_count", ov_cnt, 10);
        check("stream_run", max_run, 10);

        out_ready = 0;
        send(16'd1000, 16'd1000, 32'd984064);
        send(16'd3, 16'd7, 32'd21);
        send(16'hFFFF, 16'hFFFF, 32'hF0400000);
        a = 16'd40; b = 16'd50; cur_exp = model(16'd40, 16'd50); in_valid = 1;
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            check("bp_r_held", r, 32'd984064);
        end
        @(posedge clk);
        #1 out_ready = 1;
        send(16'd40, 16'd50, model(16'd40, 16'd50));
        send(16'd777, 16'd12345, model(16'd777, 16'd12345));
        drain();

        out_ready = 0;
        send(16'd9, 16'd9, 32'd81);
        send(16'd100, 16'd200, model(16'd100, 16'd200));
        send(16'd2, 16'd3, 32'd6);
        in_valid = 0;
        rst_n = 0;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        @(posedge clk);
        #1 rst_n = 1;
        out_ready = 1;
        ov_cnt = 0;
        repeat (5) @(negedge clk);
        check("midrst_flushed", ov_cnt, 0);
        @(posedge clk);
        #1;
        send(16'd5, 16'd6, 32'd30);
        lat_check(32'd30);
        drain();

`ifdef DRUM_EXACT_EN
        max_run = 0;
        exact_i = 1;
        send(16'd1000, 16'd1000, 32'd1000000);
        exact_i = 0;
        send(16'd1000, 16'd1000, 32'd984064);
        drain();
        check("exact_back_to_back", max_run, 2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
